if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 stall_d  input  1  decode stage stalled; ID outputs hold.
REQ-004 flush  input  1  exception flush; kill ID contents and any fetch in flight; always accompanied by redirect_valid.
REQ-005 redirect_valid  input  1  branch/jump/exception target valid this cycle.
REQ-006 redirect_pc  input  32  redirect target address.
REQ-007 inst_req  output  1  instruction SRAM-like request.
REQ-008 inst_addr  output  32  request address.
REQ-009 inst_addr_ok  input  1  request accepted.
REQ-010 inst_data_ok  input  1  read data returned.
REQ-011 inst_rdata  input  32  returned instruction word.
REQ-012 instr_d / pc_d  output  32 each  IF/ID register: instruction and its PC.
REQ-013 valid_d  output  1  IF/ID register holds a live instruction.
REQ-014 op_d 6, rs_d 5, rt_d 5, rd_d 5, funct_d 6  outputs  decode fields: instr_d[31:26], [25:21], [20:16], [15:11], [5:0]; combinational from instr_d.
REQ-015 adel_d  output  1  fetch address error for instr_d.
REQ-016 fetch_busy  output  1  high in REQ or WAIT.

Function
REQ-017 The FSM SHALL have four states: IDLE (no request), REQ (inst_req=1, waiting for addr_ok), WAIT (waiting for data_ok), HOLD (data in skid buffer, ID stalled).
REQ-018 IDLE SHALL go to REQ on the first cycle after reset deasserts.
REQ-019 In REQ, inst_addr SHALL equal pc_f and be held constant until inst_addr_ok; on inst_addr_ok the FSM SHALL go to WAIT.
REQ-020 At most one request SHALL be outstanding; inst_req SHALL be 0 in IDLE, WAIT and HOLD.
REQ-021 On data_ok in WAIT with stall_d=0, the IF/ID register SHALL load {inst_rdata, issued PC}, set valid_d=1 next cycle, and the FSM SHALL go to REQ.
REQ-022 On data_ok in WAIT with stall_d=1, the data SHALL go to a one-entry skid buffer and the FSM SHALL go to HOLD.
REQ-023 HOLD with stall_d=0 SHALL move the skid entry into IF/ID and go to REQ.
REQ-024 With stall_d=1, all ID outputs SHALL hold their values.
REQ-025 With stall_d=0 and no new instruction available, valid_d SHALL clear to 0 (bubble).
REQ-026 Next pc_f after each completed fetch SHALL be pend_pc if a pending redirect is held, otherwise pc_f+4 (32-bit wrap).
REQ-027 redirect_valid without flush SHALL be latched into pend_valid/pend_pc, so the in-flight delay-slot fetch completes normally.
REQ-028 redirect_valid in the same cycle as a completing data_ok SHALL use redirect_pc directly as the next pc_f.
REQ-029 flush SHALL force valid_d=0 next cycle, drop the skid entry, and set pc_f=redirect_pc.
REQ-030 A flush while a request is accepted-but-unreturned, or still in REQ, SHALL mark that request discard; its data_ok SHALL be dropped and the FSM SHALL go to REQ at redirect_pc.
REQ-031 flush SHALL take priority over stall_d and over any pending redirect, which it clears.

Reset
REQ-032 On rst, the block SHALL set: pc_f=32'hBFC00000, state=IDLE, valid_d=0, instr_d=0, pc_d=0, adel_d=0, pend_valid=0, discard=0, skid empty, inst_req=0.
REQ-033 rst asserted mid-fetch SHALL abandon the transaction; a data_ok arriving after reset SHALL be ignored unless state is WAIT.

Configuration
REQ-034 With IF_ADDR_ERR_EN defined, when pc_f[1:0]!=0 in REQ:
- no request SHALL be issued;
- IF/ID SHALL load instr_d=0, pc_d=pc_f, adel_d=1, valid_d=1;
- the FSM SHALL idle until flush.
REQ-035 Without IF_ADDR_ERR_EN:
- inst_addr SHALL be {pc_f[31:2],2'b00};
- adel_d SHALL be constant 0.

Verification
REQ-036 Reset, then addr_ok and data_ok one cycle apart with rdata=32'h24020005 -> inst_addr=BFC00000; next cycle valid_d=1, op_d=6'h09, rt_d=2, pc_d=BFC00000.
REQ-037 stall_d=1 when data_ok arrives -> FSM in HOLD, ID outputs unchanged; release stall -> skid instruction appears next cycle, then the next request goes to pc+4.
REQ-038 redirect_valid (target 0xBFC00100) while the delay slot at BFC00008 is in WAIT -> BFC00008 is delivered, then the next inst_addr is BFC00100.
REQ-039 flush + redirect to 0xBFC00380 while in WAIT -> the returned data is dropped, valid_d=0, and the next inst_addr is BFC00380.
REQ-040 IF_ADDR_ERR_EN build, redirect to 0xBFC00002 -> inst_req stays 0, adel_d=1, pc_d=BFC00002, instr_d=0.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-fetch SRAM-like bus: one request/accept handshake plus a data-return strobe.
interface if_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM, one-entry skid buffer,
// IF/ID pipeline register, delayed (delay-slot) redirects and flush handling.
// Optional build macro IF_ADDR_ERR_EN: misaligned pc_f raises adel_d instead of fetching.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    if_stage_if.master  ibus,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic [5:0]  op_d,
    output logic [4:0]  rs_d,
    output logic [4:0]  rt_d,
    output logic [4:0]  rd_d,
    output logic [5:0]  funct_d,
    output logic        adel_d,
    output logic        fetch_busy
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic        discard;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        addr_acc;
    logic        data_acc;
    logic [31:0] next_pc;

`ifdef IF_ADDR_ERR_EN
    logic        misalign;
    logic        adel_r;

    assign misalign       = (pc_f[1:0] != 2'b00);
    assign ibus.inst_req  = (state == S_REQ) && !misalign;
    assign ibus.inst_addr = pc_f;
    assign adel_d         = adel_r;
`else
    assign ibus.inst_req  = (state == S_REQ);
    assign ibus.inst_addr = {pc_f[31:2], 2'b00};
    assign adel_d         = 1'b0;
`endif

    assign addr_acc   = ibus.inst_req && ibus.inst_addr_ok;
    assign data_acc   = (state == S_WAIT) && ibus.inst_data_ok;
    assign fetch_busy = (state == S_REQ) || (state == S_WAIT);

    // Fetch target after a completed fetch: same-cycle redirect, then pending redirect, then sequential.
    assign next_pc = redirect_valid ? redirect_pc :
                     pend_valid     ? pend_pc     : pc_f + 32'd4;

    // Decode fields straight off the IF/ID instruction register.
    assign op_d    = instr_d[31:26];
    assign rs_d    = instr_d[25:21];
    assign rt_d    = instr_d[20:16];
    assign rd_d    = instr_d[15:11];
    assign funct_d = instr_d[5:0];

    // Fetch FSM, pending redirect, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc_f       <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
            discard    <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc    <= 32'd0;
            instr_d    <= 32'd0;
            pc_d       <= 32'd0;
            valid_d    <= 1'b0;
`ifdef IF_ADDR_ERR_EN
            adel_r     <= 1'b0;
`endif
        end else if (flush) begin
            valid_d    <= 1'b0;
            pend_valid <= 1'b0;
            pc_f       <= redirect_pc;
            case (state)
                S_REQ: begin
                    if (addr_acc) begin
                        state   <= S_WAIT;
                        discard <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (data_acc) begin
                        state   <= S_REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            if (redirect_valid) begin
                pend_valid <= 1'b1;
                pend_pc    <= redirect_pc;
            end
            if (!stall_d) begin
                valid_d <= 1'b0;
            end
            case (state)
                S_IDLE: begin
`ifdef IF_ADDR_ERR_EN
                    if (!misalign) begin
                        state <= S_REQ;
                    end
`else
                    state <= S_REQ;
`endif
                end
                S_REQ: begin
`ifdef IF_ADDR_ERR_EN
                    if (misalign) begin
                        if (!stall_d) begin
                            instr_d <= 32'd0;
                            pc_d    <= pc_f;
                            adel_r  <= 1'b1;
                            valid_d <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end else if (addr_acc) begin
                        state <= S_WAIT;
                    end
`else
                    if (addr_acc) begin
                        state <= S_WAIT;
                    end
`endif
                end
                S_WAIT: begin
                    if (data_acc) begin
                        state   <= S_REQ;
                        discard <= 1'b0;
                        if (!discard) begin
                            pc_f       <= next_pc;
                            pend_valid <= 1'b0;
                            if (stall_d) begin
                                skid_instr <= ibus.inst_rdata;
                                skid_pc    <= pc_f;
                                state      <= S_HOLD;
                            end else begin
                                instr_d <= ibus.inst_rdata;
                                pc_d    <= pc_f;
                                valid_d <= 1'b1;
`ifdef IF_ADDR_ERR_EN
                                adel_r  <= 1'b0;
`endif
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_d) begin
                        instr_d <= skid_instr;
                        pc_d    <= skid_pc;
                        valid_d <= 1'b1;
`ifdef IF_ADDR_ERR_EN
                        adel_r  <= 1'b0;
`endif
                        state   <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch handshake, stall/skid, delayed redirect, flush, wrap, reset.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_d;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic [5:0]  op_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  rd_d;
    logic [5:0]  funct_d;
    logic        adel_d;
    logic        fetch_busy;

    int n_cmp;
    int n_err;

    if_stage_if ibus ();

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_d        (stall_d),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibus           (ibus),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .valid_d        (valid_d),
        .op_d           (op_d),
        .rs_d           (rs_d),
        .rt_d           (rt_d),
        .rd_d           (rd_d),
        .funct_d        (funct_d),
        .adel_d         (adel_d),
        .fetch_busy     (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the request is presented at exp_addr, accept it, land in WAIT.
    task automatic req_accept(input logic [31:0] exp_addr);
        check("inst_req", 32'(ibus.inst_req), 32'd1);
        check("inst_addr", ibus.inst_addr, exp_addr);
        ibus.inst_addr_ok = 1'b1;
        step();
        ibus.inst_addr_ok = 1'b0;
        check("wait_busy", 32'(fetch_busy), 32'd1);
        check("wait_noreq", 32'(ibus.inst_req), 32'd0);
    endtask

    // Return one data word for the outstanding request.
    task automatic ret(input logic [31:0] data);
        ibus.inst_data_ok = 1'b1;
        ibus.inst_rdata   = data;
        step();
        ibus.inst_data_ok = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        flush          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        stall_d = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_data_ok = 1'b0;
        ibus.inst_rdata = 32'd0;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(valid_d), 32'd0);
        check("rst_instr", instr_d, 32'd0);
        check("rst_pc", pc_d, 32'd0);
        check("rst_req", 32'(ibus.inst_req), 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_adel", 32'(adel_d), 32'd0);

        // First fetch after reset, addr_ok and data_ok one cycle apart
        rst = 1'b0;
        step();
        req_accept(32'hBFC0_0000);
        ret(32'h2402_0005);
        check("f0_valid", 32'(valid_d), 32'd1);
        check("f0_instr", instr_d, 32'h2402_0005);
        check("f0_op", 32'(op_d), 32'h09);
        check("f0_rt", 32'(rt_d), 32'd2);
        check("f0_rs", 32'(rs_d), 32'd0);
        check("f0_pc", pc_d, 32'hBFC0_0000);
        check("f0_next", ibus.inst_addr, 32'hBFC0_0004);

        // No new instruction and no stall: bubble
        step();
        check("bubble_valid", 32'(valid_d), 32'd0);
        check("bubble_instr", instr_d, 32'h2402_0005);

        // Data returns under stall: skid buffer, ID holds
        req_accept(32'hBFC0_0004);
        stall_d = 1'b1;
        ret(32'h0085_1020);
        check("hold_busy", 32'(fetch_busy), 32'd0);
        check("hold_req", 32'(ibus.inst_req), 32'd0);
        check("hold_valid", 32'(valid_d), 32'd0);
        check("hold_instr", instr_d, 32'h2402_0005);
        step();
        check("hold2_pc", pc_d, 32'hBFC0_0000);
        stall_d = 1'b0;
        step();
        check("skid_valid", 32'(valid_d), 32'd1);
        check("skid_instr", instr_d, 32'h0085_1020);
        check("skid_pc", pc_d, 32'hBFC0_0004);
        check("skid_rs", 32'(rs_d), 32'd4);
        check("skid_rt", 32'(rt_d), 32'd5);
        check("skid_rd", 32'(rd_d), 32'd2);
        check("skid_funct", 32'(funct_d), 32'h20);
        check("skid_next", ibus.inst_addr, 32'hBFC0_0008);

        // Redirect while delay slot is in WAIT: slot delivered, then target
        req_accept(32'hBFC0_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0100;
        step();
        redirect_valid = 1'b0;
        ret(32'h3C01_0001);
        check("ds_valid", 32'(valid_d), 32'd1);
        check("ds_pc", pc_d, 32'hBFC0_0008);
        check("ds_op", 32'(op_d), 32'h0F);
        check("ds_target", ibus.inst_addr, 32'hBFC0_0100);

        // Redirect coincident with data_ok uses redirect_pc directly
        req_accept(32'hBFC0_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0200;
        ret(32'h0000_0000);
        redirect_valid = 1'b0;
        check("same_pc", pc_d, 32'hBFC0_0100);
        check("same_target", ibus.inst_addr, 32'hBFC0_0200);

        // Flush while in WAIT: returned data dropped
        req_accept(32'hBFC0_0200);
        do_flush(32'hBFC0_0380);
        check("flw_valid", 32'(valid_d), 32'd0);
        check("flw_busy", 32'(fetch_busy), 32'd1);
        check("flw_noreq", 32'(ibus.inst_req), 32'd0);
        ret(32'hDEAD_BEEF);
        check("flw_drop", 32'(valid_d), 32'd0);
        check("flw_req", 32'(ibus.inst_req), 32'd1);
        check("flw_addr", ibus.inst_addr, 32'hBFC0_0380);

        // Flush in the same cycle the request is accepted: discarded
        ibus.inst_addr_ok = 1'b1;
        do_flush(32'hBFC0_0400);
        ibus.inst_addr_ok = 1'b0;
        check("fla_busy", 32'(fetch_busy), 32'd1);
        check("fla_noreq", 32'(ibus.inst_req), 32'd0);
        ret(32'h1111_1111);
        check("fla_drop", 32'(valid_d), 32'd0);
        check("fla_addr", ibus.inst_addr, 32'hBFC0_0400);

        // Flush beats stall and clears a pending redirect
        req_accept(32'hBFC0_0400);
        ret(32'h8C22_0004);
        check("lw_op", 32'(op_d), 32'h23);
        check("lw_pc", pc_d, 32'hBFC0_0400);
        stall_d        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0600;
        step();
        redirect_valid = 1'b0;
        check("stall_hold", 32'(valid_d), 32'd1);
        do_flush(32'hBFC0_0500);
        check("flstall_valid", 32'(valid_d), 32'd0);
        check("flstall_addr", ibus.inst_addr, 32'hBFC0_0500);
        stall_d = 1'b0;
        req_accept(32'hBFC0_0500);
        ret(32'h0000_0000);
        check("pend_clr_pc", pc_d, 32'hBFC0_0500);
        check("pend_clr_next", ibus.inst_addr, 32'hBFC0_0504);

        // 32-bit wrap of sequential PC
        do_flush(32'hFFFF_FFFC);
        req_accept(32'hFFFF_FFFC);
        ret(32'h1000_FFFF);
        check("wrap_pc", pc_d, 32'hFFFF_FFFC);
        check("wrap_next", ibus.inst_addr, 32'h0000_0000);

        // Reset mid-fetch; late data_ok ignored outside WAIT
        req_accept(32'h0000_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmid_valid", 32'(valid_d), 32'd0);
        check("rmid_req", 32'(ibus.inst_req), 32'd0);
        ibus.inst_data_ok = 1'b1;
        ibus.inst_rdata   = 32'hABCD_1234;
        step();
        check("rlate_valid", 32'(valid_d), 32'd0);
        check("rlate_addr", ibus.inst_addr, 32'hBFC0_0000);
        step();
        ibus.inst_data_ok = 1'b0;
        check("rlate2_valid", 32'(valid_d), 32'd0);
        check("rlate2_req", 32'(ibus.inst_req), 32'd1);

        // Misaligned redirect target
        do_flush(32'hBFC0_0002);
`ifdef IF_ADDR_ERR_EN
        check("adel_noreq", 32'(ibus.inst_req), 32'd0);
        step();
        check("adel_flag", 32'(adel_d), 32'd1);
        check("adel_valid", 32'(valid_d), 32'd1);
        check("adel_pc", pc_d, 32'hBFC0_0002);
        check("adel_instr", instr_d, 32'd0);
        step();
        check("adel_idle", 32'(ibus.inst_req), 32'd0);
`else
        check("mis_req", 32'(ibus.inst_req), 32'd1);
        check("mis_addr", ibus.inst_addr, 32'hBFC0_0000);
        check("mis_adel", 32'(adel_d), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
